johnson_seq_ctrl: RTL and testbench

//  Sequencer around a WIDTH-bit Johnson (twisted-ring) counter.

---
 rtl/johnson_seq_ctrl_if.sv | 28 ++
 rtl/johnson_seq_ctrl.sv | 104 ++++++++++
 tb/tb_johnson_seq_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/johnson_seq_ctrl_if.sv
// Control and status bundle for the Johnson-ring sequencer.
// The master side issues run commands and the slave side reports ring state.
interface johnson_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic               start;
  logic [CNT_W-1:0]   run_len;
  logic               mode;
  logic               pause;
  logic               abort;
  logic [WIDTH-1:0]   q;
  logic [2*WIDTH-1:0] phase;
  logic [CNT_W-1:0]   step_cnt;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
    output start, run_len, mode, pause, abort,
    input  q, phase, step_cnt, busy, done, wrap
  );

  modport slave (
    input  start, run_len, mode, pause, abort,
    output q, phase, step_cnt, busy, done, wrap
  );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Sequencer that steps a WIDTH-bit Johnson ring for a programmed length or
// continuously, with pause/abort, a done pulse and a one-hot phase decode.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  johnson_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic [CNT_W-1:0] len_r, len_nxt;
  logic             mode_r, mode_nxt;
  logic             wrap_r, wrap_nxt;
  logic             busy_r, done_r;

  function automatic logic [WIDTH-1:0] johnson_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ~v[WIDTH-1]};
  endfunction

  function automatic logic [2*WIDTH-1:0] phase_decode(input logic [WIDTH-1:0] v);
    int ones;
    int k;
    logic [2*WIDTH-1:0] onehot;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) ones += int'(v[i]);
    k = v[WIDTH-1] ? (2*WIDTH - ones) : ones;
    for (int j = 0; j < 2*WIDTH; j++) onehot[j] = (j == k);
    return onehot;
  endfunction

  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    cnt_nxt   = cnt_r;
    len_nxt   = len_r;
    mode_nxt  = mode_r;
    wrap_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          len_nxt   = bus.run_len;
          mode_nxt  = bus.mode;
          q_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = (!bus.mode && bus.run_len == '0) ? DONE : RUN;
        end
      end
      // Leaving PAUSED steps on the same edge, so pause is a pure level gate:
      // N paused cycles delay the run by exactly N cycles.
      RUN, PAUSED: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          q_nxt     = '0;
          cnt_nxt   = '0;
        end else if (bus.pause) begin
          state_nxt = PAUSED;
        end else begin
          q_nxt     = johnson_step(q_r);
          cnt_nxt   = cnt_r + CNT_W'(1);
          wrap_nxt  = (q_nxt == '0);
          state_nxt = (!mode_r && cnt_nxt == len_r) ? DONE : RUN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      q_r    <= '0;
      cnt_r  <= '0;
      len_r  <= '0;
      mode_r <= 1'b0;
      wrap_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_r    <= q_nxt;
      cnt_r  <= cnt_nxt;
      len_r  <= len_nxt;
      mode_r <= mode_nxt;
      wrap_r <= wrap_nxt;
      busy_r <= (state_nxt == RUN) || (state_nxt == PAUSED);
      done_r <= (state_nxt == DONE);
    end
  end

  assign bus.q        = q_r;
  assign bus.phase    = phase_decode(q_r);
  assign bus.step_cnt = cnt_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.wrap     = wrap_r;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl: a ring-position model checked every
// cycle, plus hand-computed literal checkpoints for each scenario.
module tb_johnson_seq_ctrl;
  localparam int W = 4;
  localparam int C = 8;

  logic clk;
  logic reset_n;
  logic chk_en;
  int   n_tests;
  int   n_fail;

  johnson_seq_ctrl_if #(.WIDTH(W), .CNT_W(C)) bus ();

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ring position 0..2W-1, steps taken, run activity.
  int m_pos, m_cnt, m_len;
  bit m_mode, m_busy, m_done, m_wrap;

  function automatic logic [W-1:0] q_of(input int pos);
    int ones;
    logic [W-1:0] v;
    ones = (pos <= W) ? pos : 2*W - pos;
    v = W'((1 << ones) - 1);
    if (pos > W) v = W'(v << (W - ones));
    return v;
  endfunction

  always @(posedge clk) begin
    m_wrap = 1'b0;
    if (!reset_n) begin
      m_pos = 0; m_cnt = 0; m_len = 0; m_mode = 0; m_busy = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_len = int'(bus.run_len); m_mode = bus.mode; m_pos = 0; m_cnt = 0;
        if (!bus.mode && bus.run_len == 0) m_done = 1;
        else m_busy = 1;
      end
    end else if (bus.abort) begin
      m_busy = 0; m_pos = 0; m_cnt = 0;
    end else if (!bus.pause) begin
      m_pos = (m_pos + 1) % (2*W);
      m_cnt = (m_cnt + 1) % (1 << C);
      m_wrap = (m_pos == 0);
      if (!m_mode && m_cnt == m_len) begin
        m_busy = 0; m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_q",     32'(bus.q),        32'(q_of(m_pos)));
      check("model_phase", 32'(bus.phase),    32'(1) << m_pos);
      check("model_cnt",   32'(bus.step_cnt), 32'(m_cnt));
      check("model_busy",  32'(bus.busy),     32'(m_busy));
      check("model_done",  32'(bus.done),     32'(m_done));
      check("model_wrap",  32'(bus.wrap),     32'(m_wrap));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge right after the edge that samples start.
  task automatic pulse_start(input int len, input logic md);
    @(negedge clk);
    bus.start = 1'b1; bus.run_len = C'(len); bus.mode = md;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 1'b0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.run_len = '0; bus.mode = 1'b0;
    bus.pause = 1'b0; bus.abort = 1'b0;
    tick(2);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Reset mid-run, start held during reset
    pulse_start(20, 1'b0);
    tick(4);
    reset_n = 1'b0; bus.start = 1'b1; bus.run_len = 8'd9;
    tick(1);
    check("rst_q", 32'(bus.q), 32'h0);
    check("rst_phase", 32'(bus.phase), 32'h01);
    check("rst_busy", 32'(bus.busy), 32'h0);
    tick(1);
    check("rst_cnt", 32'(bus.step_cnt), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    reset_n = 1'b1; bus.start = 1'b0;
    tick(1);
    check("rst_idle_busy", 32'(bus.busy), 32'h0);

    // Short single run of 3 steps
    pulse_start(3, 1'b0);
    check("r3_busy0", 32'(bus.busy), 32'h1);
    check("r3_q0", 32'(bus.q), 32'h0);
    tick(1); check("r3_q1", 32'(bus.q), 32'b0001);
    tick(1); check("r3_q2", 32'(bus.q), 32'b0011);
    tick(1);
    check("r3_q3", 32'(bus.q), 32'b0111);
    check("r3_done", 32'(bus.done), 32'h1);
    check("r3_busy", 32'(bus.busy), 32'h0);
    check("r3_cnt", 32'(bus.step_cnt), 32'd3);
    tick(1); check("r3_done_off", 32'(bus.done), 32'h0);

    // Ten steps: wrap on step 8
    pulse_start(10, 1'b0);
    tick(7); check("r10_nowrap7", 32'(bus.wrap), 32'h0);
    tick(1);
    check("r10_wrap", 32'(bus.wrap), 32'h1);
    check("r10_q8", 32'(bus.q), 32'h0);
    check("r10_ph8", 32'(bus.phase), 32'h01);
    tick(1); check("r10_wrap_off", 32'(bus.wrap), 32'h0);
    tick(1);
    check("r10_q", 32'(bus.q), 32'b0011);
    check("r10_phase", 32'(bus.phase), 32'h04);
    check("r10_done", 32'(bus.done), 32'h1);
    tick(2);

    // Pause for two cycles after step 2
    pulse_start(5, 1'b0);
    tick(2); check("p_q2", 32'(bus.q), 32'b0011);
    bus.pause = 1'b1;
    tick(1); check("p_hold1", 32'(bus.q), 32'b0011);
    tick(1); check("p_hold2", 32'(bus.q), 32'b0011);
    check("p_busy", 32'(bus.busy), 32'h1);
    bus.pause = 1'b0;
    tick(1); check("p_q3", 32'(bus.q), 32'b0111);
    tick(1); check("p_nodone4", 32'(bus.done), 32'h0);
    tick(1);
    check("p_done", 32'(bus.done), 32'h1);
    check("p_cnt", 32'(bus.step_cnt), 32'd5);
    check("p_q5", 32'(bus.q), 32'b1110);
    tick(2);

    // Abort while paused
    pulse_start(50, 1'b0);
    tick(3); bus.pause = 1'b1;
    tick(2); bus.abort = 1'b1;
    tick(1);
    check("ap_q", 32'(bus.q), 32'h0);
    check("ap_cnt", 32'(bus.step_cnt), 32'h0);
    check("ap_busy", 32'(bus.busy), 32'h0);
    check("ap_done", 32'(bus.done), 32'h0);
    bus.abort = 1'b0; bus.pause = 1'b0;
    tick(2);

    // Abort while running; the remaining steps never complete
    pulse_start(6, 1'b0);
    tick(2); bus.abort = 1'b1;
    tick(1);
    check("ar_q", 32'(bus.q), 32'h0);
    check("ar_busy", 32'(bus.busy), 32'h0);
    bus.abort = 1'b0;
    tick(6); check("ar_done", 32'(bus.done), 32'h0);

    // Continuous mode with an ignored start while busy
    pulse_start(3, 1'b1);
    tick(5);
    bus.start = 1'b1; bus.run_len = 8'd2; bus.mode = 1'b0;
    tick(1);
    bus.start = 1'b0;
    tick(14);
    check("c20_q", 32'(bus.q), 32'b1111);
    check("c20_phase", 32'(bus.phase), 32'(1) << (20 % 8));
    check("c20_cnt", 32'(bus.step_cnt), 32'd20);
    check("c20_busy", 32'(bus.busy), 32'h1);
    tick(280);
    check("c300_cnt", 32'(bus.step_cnt), 32'd44);
    check("c300_phase", 32'(bus.phase), 32'h10);
    bus.abort = 1'b1;
    tick(1);
    check("c_abort_busy", 32'(bus.busy), 32'h0);
    check("c_abort_q", 32'(bus.q), 32'h0);
    bus.abort = 1'b0;
    tick(1);

    // Zero-length single run
    pulse_start(0, 1'b0);
    check("z_done", 32'(bus.done), 32'h1);
    check("z_q", 32'(bus.q), 32'h0);
    check("z_busy", 32'(bus.busy), 32'h0);
    check("z_cnt", 32'(bus.step_cnt), 32'h0);
    tick(1); check("z_done_off", 32'(bus.done), 32'h0);
    tick(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
